iob_axi_read_slave: RTL and testbench

IOB_AXI_READ_SLAVE -- requirements
Module: iob_axi_read_slave

---
 rtl/iob_axi_read_slave_if.sv | 48 ++++
 rtl/iob_axi_read_slave.sv | 128 ++++++++++++
 tb/tb_iob_axi_read_slave.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/iob_axi_read_slave_if.sv
// Bus bundle for the AXI read slave: AR and R channels plus the synchronous RAM port.
// The slave modport belongs to the bridge; the master modport belongs to the AXI master and RAM.
interface iob_axi_read_slave_if #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
);
  localparam int NBYTES_W   = $clog2(AXI_DATA_W / 8);
  localparam int MEM_ADDR_W = AXI_ADDR_W - NBYTES_W;

  logic [AXI_ID_W-1:0]   axi_arid_i;
  logic [AXI_ADDR_W-1:0] axi_araddr_i;
  logic [AXI_LEN_W-1:0]  axi_arlen_i;
  logic [2:0]            axi_arsize_i;
  logic [1:0]            axi_arburst_i;
  logic                  axi_arvalid_i;
  logic                  axi_arready_o;

  logic [AXI_ID_W-1:0]   axi_rid_o;
  logic [AXI_DATA_W-1:0] axi_rdata_o;
  logic [1:0]            axi_rresp_o;
  logic                  axi_rlast_o;
  logic                  axi_rvalid_o;
  logic                  axi_rready_i;

  logic                  mem_en_o;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [AXI_DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i,
    output axi_arready_o,
    output axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    input  axi_rready_i,
    output mem_en_o, mem_addr_o,
    input  mem_rdata_i
  );

  modport master (
    output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i,
    input  axi_arready_o,
    input  axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    output axi_rready_i,
    input  mem_en_o, mem_addr_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/iob_axi_read_slave.sv
// AXI4 read-only slave in front of a single-cycle synchronous RAM: one burst at a time,
// one RAM fetch per beat, unsupported bursts answered with SLVERR beats.
module iob_axi_read_slave #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
) (
  input logic                 clk_i,
  input logic                 reset_i,
  iob_axi_read_slave_if.slave axi
);
  localparam int NBYTES_W   = $clog2(AXI_DATA_W / 8);
  localparam int MEM_ADDR_W = AXI_ADDR_W - NBYTES_W;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [AXI_LEN_W-1:0]  LEN_ONE  = 1;
  localparam logic [MEM_ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [2:0]            BEAT_SIZE = 3'(NBYTES_W);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    ERR
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [AXI_ID_W-1:0]   id_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [AXI_LEN_W-1:0]  len_q;
  logic [1:0]            burst_q;
  logic [AXI_LEN_W-1:0]  cnt_q;

  logic ar_hs;
  logic req_legal;
  logic beating;
  logic r_hs;
  logic last_beat;

  always_comb begin
    ar_hs     = (state_q == IDLE) && axi.axi_arvalid_i;
    req_legal = (axi.axi_arsize_i == BEAT_SIZE) && !axi.axi_arburst_i[1];
    beating   = (state_q == SEND) || (state_q == ERR);
    r_hs      = beating && axi.axi_rready_i;
    last_beat = (cnt_q == len_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every beat of a good burst takes a FETCH cycle for the RAM read, then waits in SEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d = req_legal ? FETCH : ERR;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        if (axi.axi_rready_i) begin
          state_d = last_beat ? IDLE : FETCH;
        end
      end
      ERR: begin
        if (axi.axi_rready_i && last_beat) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else if (ar_hs) begin
      id_q    <= axi.axi_arid_i;
      addr_q  <= axi.axi_araddr_i[AXI_ADDR_W-1:NBYTES_W];
      len_q   <= axi.axi_arlen_i;
      burst_q <= axi.axi_arburst_i;
      cnt_q   <= '0;
    end else if (r_hs && !last_beat) begin
      cnt_q <= cnt_q + LEN_ONE;
      // The word address rolls over at the top of RAM; FIXED bursts reread the same word.
      if ((state_q == SEND) && (burst_q == BURST_INCR)) begin
        addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  // RAM data is held until the next enable, so passing it straight through keeps rdata stable.
  always_comb begin
    axi.axi_arready_o = (state_q == IDLE);
    axi.axi_rvalid_o  = beating;
    axi.axi_rlast_o   = beating && last_beat;
    axi.axi_rid_o     = id_q;
    axi.axi_rdata_o   = '0;
    axi.axi_rresp_o   = RESP_OKAY;
    axi.mem_en_o      = (state_q == FETCH);
    axi.mem_addr_o    = addr_q;
    if (state_q == SEND) begin
      axi.axi_rdata_o = axi.mem_rdata_i;
    end
    if (state_q == ERR) begin
      axi.axi_rresp_o = RESP_SLVERR;
    end
  end
endmodule

// File: tb/tb_iob_axi_read_slave.sv
// Self-checking bench for iob_axi_read_slave: directed bursts plus random requests compared
// beat by beat against an expected-beat list built from the burst rules.
module tb_iob_axi_read_slave;
  localparam int AXI_ADDR_W = 24;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 1;
  localparam int AXI_LEN_W  = 8;
  localparam int MEM_ADDR_W = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] salt;
  int          vectors = 0;
  int          miscompares = 0;

  iob_axi_read_slave_if #(
    .AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W), .AXI_ID_W(AXI_ID_W), .AXI_LEN_W(AXI_LEN_W)
  ) axi ();

  iob_axi_read_slave #(
    .AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W), .AXI_ID_W(AXI_ID_W), .AXI_LEN_W(AXI_LEN_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .axi    (axi)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [MEM_ADDR_W-1:0] a);
    return ({10'd0, a} * 32'h9E37_79B1) ^ salt;
  endfunction

  // Synchronous RAM: word appears the cycle after the enable and is held until the next one.
  always @(posedge clk) begin
    if (axi.mem_en_o === 1'b1) axi.mem_rdata_i <= ram_word(axi.mem_addr_o);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rvalid"}, 64'(axi.axi_rvalid_o), 64'd0);
    checkOutput({tag, "_rlast"}, 64'(axi.axi_rlast_o), 64'd0);
    checkOutput({tag, "_rresp"}, 64'(axi.axi_rresp_o), 64'd0);
    checkOutput({tag, "_rid"}, 64'(axi.axi_rid_o), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(axi.axi_rdata_o), 64'd0);
    checkOutput({tag, "_mem_en"}, 64'(axi.mem_en_o), 64'd0);
    checkOutput({tag, "_mem_addr"}, 64'(axi.mem_addr_o), 64'd0);
    checkOutput({tag, "_arready"}, 64'(axi.axi_arready_o), 64'd1);
  endtask

  // Issues one request from a negedge and follows every beat; returns at a negedge in IDLE.
  // stall_beat/stall_cycles hold rready low on one beat; rand_stall stalls every beat randomly.
  task automatic applyStimulus(input logic [AXI_ID_W-1:0] id, input logic [23:0] byte_addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int stall_beat,
                               input int stall_cycles, input bit rand_stall);
    logic                  legal;
    logic [MEM_ADDR_W-1:0] word;
    logic [31:0]           exp_data;
    int                    n;
    int                    stall;
    legal = (size == 3'd2) && (burst == 2'b00 || burst == 2'b01);
    axi.axi_arid_i    = id;
    axi.axi_araddr_i  = byte_addr;
    axi.axi_arlen_i   = len;
    axi.axi_arsize_i  = size;
    axi.axi_arburst_i = burst;
    axi.axi_arvalid_i = 1'b1;
    n = 0;
    while (axi.axi_arready_o !== 1'b1 && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checkOutput("ar_ready", 64'(axi.axi_arready_o), 64'd1);
    @(posedge clk); @(negedge clk);
    axi.axi_arvalid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      word     = (burst == 2'b01) ? byte_addr[23:2] + MEM_ADDR_W'(i) : byte_addr[23:2];
      exp_data = legal ? ram_word(word) : 32'd0;
      if (legal) begin
        checkOutput($sformatf("fetch_en[%0d]", i), 64'(axi.mem_en_o), 64'd1);
        checkOutput($sformatf("fetch_addr[%0d]", i), 64'(axi.mem_addr_o), 64'(word));
        checkOutput($sformatf("fetch_rvalid[%0d]", i), 64'(axi.axi_rvalid_o), 64'd0);
        checkOutput($sformatf("fetch_rlast[%0d]", i), 64'(axi.axi_rlast_o), 64'd0);
        @(posedge clk); @(negedge clk);
      end
      stall = rand_stall ? int'($urandom_range(0, 2)) : ((i == stall_beat) ? stall_cycles : 0);
      for (int k = 0; k <= stall; k++) begin
        axi.axi_rready_i  = (k == stall);
        axi.axi_arvalid_i = 1'($urandom_range(0, 1));
        axi.axi_araddr_i  = 24'($urandom);
        axi.axi_arid_i    = 1'($urandom_range(0, 1));
        checkOutput($sformatf("rvalid[%0d]", i), 64'(axi.axi_rvalid_o), 64'd1);
        checkOutput($sformatf("rdata[%0d]", i), 64'(axi.axi_rdata_o), 64'(exp_data));
        checkOutput($sformatf("rlast[%0d]", i), 64'(axi.axi_rlast_o), 64'(i == int'(len)));
        checkOutput($sformatf("rresp[%0d]", i), 64'(axi.axi_rresp_o), legal ? 64'd0 : 64'd2);
        checkOutput($sformatf("rid[%0d]", i), 64'(axi.axi_rid_o), 64'(id));
        checkOutput($sformatf("beat_mem_en[%0d]", i), 64'(axi.mem_en_o), 64'd0);
        checkOutput($sformatf("busy_arready[%0d]", i), 64'(axi.axi_arready_o), 64'd0);
        @(posedge clk); @(negedge clk);
      end
    end
    axi.axi_arvalid_i = 1'b0;
    checkOutput("done_rvalid", 64'(axi.axi_rvalid_o), 64'd0);
    checkOutput("done_arready", 64'(axi.axi_arready_o), 64'd1);
  endtask

  initial begin
    logic [23:0] r_addr;
    logic [2:0]  r_size;
    axi.axi_arid_i    = '0;
    axi.axi_araddr_i  = '0;
    axi.axi_arlen_i   = '0;
    axi.axi_arsize_i  = 3'd2;
    axi.axi_arburst_i = 2'b01;
    axi.axi_arvalid_i = 1'b0;
    axi.axi_rready_i  = 1'b1;
    salt = $urandom;

    @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    $display("[TB] directed bursts");
    applyStimulus(1'b1, 24'h000100, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    applyStimulus(1'b0, 24'h000020, 8'd2, 3'd2, 2'b00, -1, 0, 1'b0);
    applyStimulus(1'b1, 24'h000400, 8'd3, 3'd2, 2'b01, 1, 5, 1'b0);
    applyStimulus(1'b0, 24'h000080, 8'd1, 3'd2, 2'b10, -1, 0, 1'b0);
    applyStimulus(1'b1, 24'h000084, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);
    applyStimulus(1'b0, 24'hFFFFFC, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0);
    applyStimulus(1'b1, 24'h000010, 8'd2, 3'd1, 2'b01, 0, 2, 1'b0);
    applyStimulus(1'b0, 24'h000040, 8'd1, 3'd2, 2'b11, -1, 0, 1'b0);

    $display("[TB] reset in the middle of a burst");
    axi.axi_arid_i    = 1'b1;
    axi.axi_araddr_i  = 24'h000200;
    axi.axi_arlen_i   = 8'd3;
    axi.axi_arsize_i  = 3'd2;
    axi.axi_arburst_i = 2'b01;
    axi.axi_arvalid_i = 1'b1;
    axi.axi_rready_i  = 1'b0;
    checkOutput("mid_arready", 64'(axi.axi_arready_o), 64'd1);
    @(posedge clk); @(negedge clk);
    axi.axi_arvalid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("mid_rvalid_before", 64'(axi.axi_rvalid_o), 64'd1);
    #2 reset = 1'b1;
    #1 checkIdleOutputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    axi.axi_rready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("mid_no_beat", 64'(axi.axi_rvalid_o), 64'd0);
      checkOutput("mid_arready_after", 64'(axi.axi_arready_o), 64'd1);
    end
    applyStimulus(1'b1, 24'h000300, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);

    $display("[TB] random requests");
    for (int t = 0; t < 30; t++) begin
      r_addr = 24'($urandom);
      if ($urandom_range(0, 3) == 0) r_addr = 24'hFFFFF0 | 24'($urandom_range(0, 15));
      r_size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      applyStimulus(1'($urandom_range(0, 1)), r_addr, 8'($urandom_range(0, 7)), r_size,
                    2'($urandom_range(0, 3)), -1, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
